// File: rtl/call_ui_ctrl_pkg.sv
// rtl/call_ui_ctrl_pkg.sv - shared encodings for the call/menu control core
package call_ui_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_INIT     = 3'd0,
    ST_IDLE     = 3'd1,
    ST_MENU     = 3'd2,
    ST_DIALING  = 3'd3,
    ST_OUTGOING = 3'd4,
    ST_INCOMING = 3'd5,
    ST_BUSY     = 3'd6,
    ST_ENDING   = 3'd7
  } ui_state_e;

  typedef enum logic [2:0] {
    CMD_NONE      = 3'd0,
    CMD_DIAL      = 3'd1,
    CMD_ACCEPT    = 3'd2,
    CMD_REJECT    = 3'd3,
    CMD_HANGUP    = 3'd4,
    CMD_VOICEMAIL = 3'd5
  } ui_cmd_e;

  localparam logic [2:0] INC_CONNECTED = 3'd1;
  localparam logic [2:0] INC_REJECTED  = 3'd2;
  localparam logic [2:0] INC_INCOMING  = 3'd5;
  localparam logic [2:0] INC_ENDED     = 3'd6;

  localparam logic [5:0] ITEM_CALL      = 6'd0;
  localparam logic [5:0] ITEM_CALLER_ID = 6'd0;
  localparam logic [5:0] ITEM_ACCEPT    = 6'd1;
  localparam logic [5:0] ITEM_REJECT    = 6'd2;
  localparam logic [5:0] ITEM_END_CALL  = 6'd1;

  // Highest selectable item in a state; states without a menu pin the item at 0.
  function automatic logic [5:0] last_item(input ui_state_e st, input logic [5:0] menu_last);
    case (st)
      ST_MENU:     last_item = menu_last;
      ST_INCOMING: last_item = ITEM_REJECT;
      ST_BUSY:     last_item = ITEM_END_CALL;
      default:     last_item = 6'd0;
    endcase
  endfunction

endpackage

// File: rtl/call_ui_ctrl_timer.sv
// rtl/call_ui_ctrl_timer.sv - loadable saturating down-counter with single fire strobe
module call_ui_ctrl_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         fire
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  // Fires in the last cycle of the window; loading 0 disarms the timer.
  assign fire = (cnt_q == W'(1));

endmodule

// File: rtl/call_ui_ctrl.sv
// rtl/call_ui_ctrl.sv - call-control/menu FSM with dial shift register and timeouts
module call_ui_ctrl
  import call_ui_ctrl_pkg::*;
#(
  parameter int DIGITS     = 2,
  parameter int MENU_ITEMS = 4,
  parameter int DIAL_TO    = 1000000,
  parameter int RING_TO    = 2000000,
  parameter int END_TO     = 500000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enter,
  input  logic                         up,
  input  logic                         down,
  input  logic                         left,
  input  logic                         right,
  input  logic                         digit_valid,
  input  logic [3:0]                   digit,
  input  logic                         inc_valid,
  input  logic [2:0]                   inc_command,
  output logic                         command_valid,
  output logic [2:0]                   command,
  output logic [4*DIGITS-1:0]          phn_num,
  output logic [$clog2(DIGITS+1)-1:0]  dial_count,
  output logic [2:0]                   current_state,
  output logic [5:0]                   current_menu_item,
  output logic                         timeout_evt
);

  localparam int CW     = $clog2(DIGITS + 1);
  localparam int PW     = 4 * DIGITS;
  localparam int MAX_TO = (DIAL_TO > RING_TO) ? ((DIAL_TO > END_TO) ? DIAL_TO : END_TO)
                                              : ((RING_TO > END_TO) ? RING_TO : END_TO);
  localparam int TW     = $clog2(MAX_TO + 1);

  localparam logic [TW-1:0] DIAL_LD   = TW'(DIAL_TO);
  localparam logic [TW-1:0] RING_LD   = TW'(RING_TO);
  localparam logic [TW-1:0] END_LD    = TW'(END_TO);
  localparam logic [CW-1:0] FULL      = CW'(DIGITS);
  localparam logic [5:0]    MENU_LAST = 6'(MENU_ITEMS - 1);

  ui_state_e     state_q, state_d;
  ui_cmd_e       cmd_q, cmd_d;
  logic [5:0]    item_q, item_d;
  logic [PW-1:0] phn_q, phn_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          cmd_valid_q, cmd_valid_d;
  logic          tevt_q, tevt_d;

  logic          tmr_fire, tmr_load;
  logic [TW-1:0] tmr_val;
  logic [5:0]    last;
  logic          digit_ok, activity;

  call_ui_ctrl_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .fire     (tmr_fire)
  );

  always_comb begin
    state_d     = state_q;
    item_d      = item_q;
    phn_d       = phn_q;
    cnt_d       = cnt_q;
    cmd_d       = CMD_NONE;
    tevt_d      = 1'b0;
    digit_ok    = digit_valid && (digit <= 4'd9);
    activity    = enter | up | down | left | right | digit_ok;
    last        = last_item(state_q, MENU_LAST);

    // One event per cycle, taken in fixed priority order.
    if (inc_valid) begin
      case (state_q)
        ST_IDLE, ST_MENU, ST_DIALING:
          if (inc_command == INC_INCOMING) state_d = ST_INCOMING;
        ST_OUTGOING:
          if (inc_command == INC_CONNECTED) state_d = ST_BUSY;
          else if (inc_command == INC_REJECTED || inc_command == INC_ENDED) state_d = ST_IDLE;
        ST_INCOMING, ST_BUSY, ST_ENDING:
          if (inc_command == INC_ENDED) state_d = ST_IDLE;
        default: ;
      endcase
    end else if (tmr_fire) begin
      tevt_d = 1'b1;
      case (state_q)
        ST_DIALING:  state_d = ST_IDLE;
        ST_INCOMING: begin state_d = ST_IDLE;   cmd_d = CMD_VOICEMAIL; end
        ST_OUTGOING: begin state_d = ST_ENDING; cmd_d = CMD_HANGUP;    end
        ST_ENDING:   state_d = ST_IDLE;
        default: ;
      endcase
    end else if (enter) begin
      case (state_q)
        ST_INIT: state_d = ST_IDLE;
        ST_MENU: if (item_q == ITEM_CALL) state_d = ST_DIALING;
        ST_DIALING:
          if (cnt_q == FULL) begin state_d = ST_OUTGOING; cmd_d = CMD_DIAL; end
        ST_INCOMING:
          if (item_q == ITEM_ACCEPT) begin state_d = ST_BUSY; cmd_d = CMD_ACCEPT; end
          else if (item_q == ITEM_REJECT) begin state_d = ST_IDLE; cmd_d = CMD_REJECT; end
        ST_BUSY:
          if (item_q == ITEM_END_CALL) begin state_d = ST_ENDING; cmd_d = CMD_HANGUP; end
        default: ;
      endcase
    end else if (up) begin
      item_d = (item_q == 6'd0) ? last : item_q - 6'd1;
    end else if (down) begin
      item_d = (item_q == last) ? 6'd0 : item_q + 6'd1;
    end else if (left) begin
      if (state_q == ST_MENU) begin
        state_d = ST_IDLE;
      end else if (state_q == ST_DIALING) begin
        if (cnt_q != '0) begin
          phn_d = phn_q >> 4;
          cnt_d = cnt_q - CW'(1);
        end else begin
          state_d = ST_MENU;
        end
      end
    end else if (right) begin
      if (state_q == ST_IDLE) state_d = ST_MENU;
    end else if (digit_ok && state_q == ST_DIALING && cnt_q != FULL) begin
      phn_d = (phn_q << 4) | PW'(digit);
      cnt_d = cnt_q + CW'(1);
    end

    if (state_d != state_q) begin
      item_d = 6'd0;
      if (state_d == ST_DIALING) begin
        phn_d = '0;
        cnt_d = '0;
      end
    end

    cmd_valid_d = (cmd_d != CMD_NONE);
    // Dialing activity keeps the abandon timer from running out under the user.
    tmr_load    = (state_d != state_q) || (state_q == ST_DIALING && activity);
    case (state_d)
      ST_DIALING:              tmr_val = DIAL_LD;
      ST_OUTGOING, ST_INCOMING: tmr_val = RING_LD;
      ST_ENDING:               tmr_val = END_LD;
      default:                 tmr_val = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_INIT;
      item_q      <= 6'd0;
      phn_q       <= '0;
      cnt_q       <= '0;
      cmd_q       <= CMD_NONE;
      cmd_valid_q <= 1'b0;
      tevt_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      item_q      <= item_d;
      phn_q       <= phn_d;
      cnt_q       <= cnt_d;
      cmd_q       <= cmd_d;
      cmd_valid_q <= cmd_valid_d;
      tevt_q      <= tevt_d;
    end
  end

  assign command_valid     = cmd_valid_q;
  assign command           = cmd_q;
  assign phn_num           = phn_q;
  assign dial_count        = cnt_q;
  assign current_state     = state_q;
  assign current_menu_item = item_q;
  assign timeout_evt       = tevt_q;

endmodule
